// File: rtl/message_scheduler_if.sv
// Block-in / schedule-out handshake bundle between block assembly, the scheduler and hasher.
// Both directions are valid/ready; the schedule is a 64-word array, W0 at index 0.
interface message_scheduler_if;
    logic                blk_valid;
    logic                blk_ready;
    logic [0:511]        block_in;
    logic                sched_valid;
    logic                sched_ready;
    logic [0:63][0:31]   message_schedule;

    modport master (
        output blk_valid, block_in, sched_ready,
        input  blk_ready, sched_valid, message_schedule
    );

    modport slave (
        input  blk_valid, block_in, sched_ready,
        output blk_ready, sched_valid, message_schedule
    );
endinterface

// File: rtl/message_scheduler.sv
// SHA-256 message schedule expander: 48 cycles from block accept to sched_valid.
// Ready only in IDLE; the finished schedule is held until the consumer takes it.
package sigma_functions;
    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction
endpackage

module message_scheduler
    import sigma_functions::*;
(
    input  logic                clk,
    input  logic                rst_n,
    message_scheduler_if.slave  bus,
    output logic                busy
);

    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

    state_t             state_q, state_d;
    logic [5:0]         t_q, t_d;
    logic [0:63][0:31]  sched_q, sched_d;

    logic [5:0]         idx2, idx7, idx15, idx16;
    logic [31:0]        w_new;

    // Taps are always behind t, so the whole adder chain reads settled registers.
    always_comb begin
        idx2  = t_q - 6'd2;
        idx7  = t_q - 6'd7;
        idx15 = t_q - 6'd15;
        idx16 = t_q - 6'd16;
        w_new = sigma1(sched_q[idx2]) + sched_q[idx7]
              + sigma0(sched_q[idx15]) + sched_q[idx16];
    end

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        sched_d = sched_q;
        case (state_q)
            IDLE: begin
                if (bus.blk_valid) begin
                    for (int i = 0; i < 16; i++) begin
                        sched_d[i] = bus.block_in[32*i +: 32];
                    end
                    t_d     = 6'd16;
                    state_d = EXPAND;
                end
            end
            EXPAND: begin
                sched_d[t_q] = w_new;
                if (t_q == 6'd63) begin
                    state_d = DONE;
                end else begin
                    t_d = t_q + 6'd1;
                end
            end
            DONE: begin
                if (bus.sched_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            t_q     <= 6'd16;
            sched_q <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            sched_q <= sched_d;
        end
    end

    assign bus.blk_ready        = (state_q == IDLE);
    assign bus.sched_valid      = (state_q == DONE);
    assign bus.message_schedule = sched_q;
    assign busy                 = (state_q == EXPAND);

endmodule
